// File: rtl/inst_fetch.sv
// Instruction fetch responder: takes a pc/ce request and reads four consecutive bytes
// from a byte-wide synchronous memory, returning one little-endian 32-bit word.
module inst_fetch #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc,
    input  logic                  ce,
    output logic                  stall_req,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_rd,
    input  logic [7:0]            mem_din
);

    typedef enum logic {
        S_IDLE,
        S_FETCH
    } state_t;

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [23:0]           r_buf;

    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_unused_pc_hi;

    // Address of the next byte to request; wraps naturally at 2^ADDR_WIDTH.
    assign w_addr_next    = r_addr_q + ADDR_WIDTH'(r_cnt) + ADDR_WIDTH'(1);
    assign w_unused_pc_hi = ^pc[31:ADDR_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_addr_q   <= '0;
            r_buf      <= 24'd0;
            mem_a      <= '0;
            mem_rd     <= 1'b0;
            stall_req  <= 1'b0;
            inst       <= 32'h0000_0000;
            inst_valid <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ce) begin
                        r_addr_q  <= pc[ADDR_WIDTH-1:0];
                        mem_a     <= pc[ADDR_WIDTH-1:0];
                        mem_rd    <= 1'b1;
                        stall_req <= 1'b1;
                        r_cnt     <= 3'd0;
                        r_state   <= S_FETCH;
                    end else begin
                        mem_rd    <= 1'b0;
                        stall_req <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt <= 3'd2) begin
                        mem_a <= w_addr_next;
                    end
                    if (r_cnt == 3'd3) begin
                        mem_rd <= 1'b0;
                    end
                    // Read data lags the address by one cycle, so lane (cnt-1) arrives now.
                    case (r_cnt)
                        3'd1: r_buf[7:0]   <= mem_din;
                        3'd2: r_buf[15:8]  <= mem_din;
                        3'd3: r_buf[23:16] <= mem_din;
                        3'd4: begin
                            inst       <= {mem_din, r_buf};
                            inst_valid <= 1'b1;
                            stall_req  <= 1'b0;
                            r_cnt      <= 3'd0;
                            r_state    <= S_IDLE;
                        end
                        default: ;
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with a byte-wide 1-cycle synchronous memory model.
// s_*[k] hold the outputs sampled 1 time unit after fetch edge Ek.
module tb_inst_fetch;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   pc  = 32'd0;
    logic          ce  = 1'b0;
    logic          stall_req;
    logic [31:0]   inst;
    logic          inst_valid;
    logic [AW-1:0] mem_a;
    logic          mem_rd;
    logic [7:0]    mem_din = 8'd0;

    logic [7:0]    mem [0:(1<<AW)-1];

    logic [AW-1:0] s_a    [0:15];
    logic          s_rd   [0:15];
    logic          s_st   [0:15];
    logic          s_v    [0:15];
    logic [31:0]   s_inst [0:15];

    int n_checks = 0;
    int n_errors = 0;

    inst_fetch #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .ce         (ce),
        .stall_req  (stall_req),
        .inst       (inst),
        .inst_valid (inst_valid),
        .mem_a      (mem_a),
        .mem_rd     (mem_rd),
        .mem_din    (mem_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_din <= mem[mem_a];
    end

    // Records n cycles of outputs; applies new_pc/new_ce right after sample chg_at.
    task automatic capture(input int n, input int chg_at, input logic [31:0] new_pc,
                           input logic new_ce);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            s_a[i]    = mem_a;
            s_rd[i]   = mem_rd;
            s_st[i]   = stall_req;
            s_v[i]    = inst_valid;
            s_inst[i] = inst;
            if (i == chg_at) begin
                pc = new_pc;
                ce = new_ce;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (mem_a !== 17'd0) begin n_errors++; $display("FAIL reset_mem_a: got %h expected 0", mem_a); end
        n_checks++; if (mem_rd !== 1'b0) begin n_errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
        n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
        n_checks++; if (inst !== 32'h0) begin n_errors++; $display("FAIL reset_inst: got %h expected 0", inst); end
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_single();
        pc = 32'd0; ce = 1'b1;
        capture(7, 0, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (s_a[k] !== AW'(k)) begin n_errors++; $display("FAIL single_mem_a[%0d]: got %h expected %h", k, s_a[k], AW'(k)); end
            n_checks++; if (s_rd[k] !== 1'b1) begin n_errors++; $display("FAIL single_mem_rd[%0d]: got %b expected 1", k, s_rd[k]); end
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (s_st[k] !== 1'b1) begin n_errors++; $display("FAIL single_stall[%0d]: got %b expected 1", k, s_st[k]); end
            n_checks++; if (s_v[k] !== 1'b0) begin n_errors++; $display("FAIL single_valid[%0d]: got %b expected 0", k, s_v[k]); end
        end
        n_checks++; if (s_rd[4] !== 1'b0) begin n_errors++; $display("FAIL single_rd_drop: got %b expected 0", s_rd[4]); end
        n_checks++; if (s_v[5] !== 1'b1) begin n_errors++; $display("FAIL single_valid_e5: got %b expected 1", s_v[5]); end
        n_checks++; if (s_inst[5] !== 32'h00100513) begin n_errors++; $display("FAIL single_inst: got %h expected 00100513", s_inst[5]); end
        n_checks++; if (s_st[5] !== 1'b0) begin n_errors++; $display("FAIL single_stall_e5: got %b expected 0", s_st[5]); end
        n_checks++; if (s_v[6] !== 1'b0) begin n_errors++; $display("FAIL single_valid_e6: got %b expected 0", s_v[6]); end
        $display("single: pc=00000000 inst=%h", s_inst[5]);
    endtask

    task automatic test_back_to_back();
        pc = 32'd0; ce = 1'b1;
        capture(12, 0, 32'd4, 1'b1);
        ce = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (s_a[6+k] !== AW'(4+k)) begin n_errors++; $display("FAIL b2b_mem_a[%0d]: got %h expected %h", 6+k, s_a[6+k], AW'(4+k)); end
        end
        n_checks++; if (s_st[5] !== 1'b0) begin n_errors++; $display("FAIL b2b_stall_gap: got %b expected 0", s_st[5]); end
        n_checks++; if (s_st[4] !== 1'b1 || s_st[6] !== 1'b1) begin n_errors++; $display("FAIL b2b_stall_around_gap: got %b%b expected 11", s_st[4], s_st[6]); end
        n_checks++; if (s_v[5] !== 1'b1) begin n_errors++; $display("FAIL b2b_valid1: got %b expected 1", s_v[5]); end
        n_checks++; if (s_inst[5] !== 32'h00100513) begin n_errors++; $display("FAIL b2b_inst1: got %h expected 00100513", s_inst[5]); end
        for (int k = 6; k < 11; k++) begin
            n_checks++; if (s_v[k] !== 1'b0) begin n_errors++; $display("FAIL b2b_valid_between[%0d]: got %b expected 0", k, s_v[k]); end
        end
        n_checks++; if (s_v[11] !== 1'b1) begin n_errors++; $display("FAIL b2b_valid2: got %b expected 1", s_v[11]); end
        n_checks++; if (s_inst[11] !== 32'h00100093) begin n_errors++; $display("FAIL b2b_inst2: got %h expected 00100093", s_inst[11]); end
        $display("back_to_back: inst1=%h inst2=%h", s_inst[5], s_inst[11]);
        capture(2, -1, 32'd0, 1'b0);
    endtask

    task automatic test_disturb();
        pc = 32'd8; ce = 1'b1;
        capture(8, 1, 32'h40, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (s_a[k] !== AW'(8+k)) begin n_errors++; $display("FAIL disturb_mem_a[%0d]: got %h expected %h", k, s_a[k], AW'(8+k)); end
        end
        n_checks++; if (s_v[5] !== 1'b1) begin n_errors++; $display("FAIL disturb_valid: got %b expected 1", s_v[5]); end
        n_checks++; if (s_inst[5] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL disturb_inst: got %h expected deadbeef", s_inst[5]); end
        n_checks++; if (s_st[6] !== 1'b0 || s_st[7] !== 1'b0) begin n_errors++; $display("FAIL disturb_no_refetch: got %b%b expected 00", s_st[6], s_st[7]); end
        $display("disturb: pc=00000008 inst=%h", s_inst[5]);
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [0:3];
        exp_a[0] = 17'h1FFFE; exp_a[1] = 17'h1FFFF; exp_a[2] = 17'h00000; exp_a[3] = 17'h00001;
        pc = 32'h0001FFFE; ce = 1'b1;
        capture(7, 0, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (s_a[k] !== exp_a[k]) begin n_errors++; $display("FAIL wrap_mem_a[%0d]: got %h expected %h", k, s_a[k], exp_a[k]); end
        end
        n_checks++; if (s_v[5] !== 1'b1) begin n_errors++; $display("FAIL wrap_valid: got %b expected 1", s_v[5]); end
        n_checks++; if (s_inst[5] !== 32'h0513BBAA) begin n_errors++; $display("FAIL wrap_inst: got %h expected 0513bbaa", s_inst[5]); end
        $display("wrap: pc=0001fffe inst=%h", s_inst[5]);
    endtask

    task automatic test_misaligned_hi();
        pc = 32'hFFFE0002; ce = 1'b1;
        capture(7, 0, 32'd0, 1'b0);
        n_checks++; if (s_a[0] !== 17'h00002) begin n_errors++; $display("FAIL mis_mem_a0: got %h expected 00002", s_a[0]); end
        n_checks++; if (s_a[3] !== 17'h00005) begin n_errors++; $display("FAIL mis_mem_a3: got %h expected 00005", s_a[3]); end
        n_checks++; if (s_inst[5] !== 32'h00930010) begin n_errors++; $display("FAIL mis_inst: got %h expected 00930010", s_inst[5]); end
        $display("misaligned: pc=fffe0002 inst=%h", s_inst[5]);
    endtask

    task automatic test_idle_hold();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (mem_rd !== 1'b0 || stall_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h00930010) begin
                n_errors++;
                $display("FAIL idle_hold[%0d]: got rd=%b st=%b v=%b inst=%h expected rd=0 st=0 v=0 inst=00930010",
                         k, mem_rd, stall_req, inst_valid, inst);
            end
        end
        $display("idle_hold: 20 cycles inst=%h", inst);
    endtask

    task automatic test_async_reset();
        pc = 32'd4; ce = 1'b1;
        @(posedge clk); #1; ce = 1'b0;
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (mem_a !== 17'd0) begin n_errors++; $display("FAIL areset_mem_a: got %h expected 0", mem_a); end
        n_checks++; if (mem_rd !== 1'b0) begin n_errors++; $display("FAIL areset_mem_rd: got %b expected 0", mem_rd); end
        n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL areset_stall: got %b expected 0", stall_req); end
        n_checks++; if (inst !== 32'h0) begin n_errors++; $display("FAIL areset_inst: got %h expected 0", inst); end
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL areset_valid: got %b expected 0", inst_valid); end
        #2 rst = 1'b0;
        capture(8, -1, 32'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (s_v[k] !== 1'b0 || s_st[k] !== 1'b0) begin n_errors++; $display("FAIL areset_aborted[%0d]: got v=%b st=%b expected 0 0", k, s_v[k], s_st[k]); end
        end
        pc = 32'd8; ce = 1'b1;
        capture(7, 0, 32'd0, 1'b0);
        n_checks++; if (s_a[0] !== 17'd8) begin n_errors++; $display("FAIL areset_next_mem_a: got %h expected 00008", s_a[0]); end
        n_checks++; if (s_v[5] !== 1'b1) begin n_errors++; $display("FAIL areset_next_valid: got %b expected 1", s_v[5]); end
        n_checks++; if (s_inst[5] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL areset_next_inst: got %h expected deadbeef", s_inst[5]); end
        $display("async_reset: refetch pc=00000008 inst=%h", s_inst[5]);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h00; mem[6] = 8'h10; mem[7] = 8'h00;
        mem[8] = 8'hEF; mem[9] = 8'hBE; mem[10] = 8'hAD; mem[11] = 8'hDE;
        mem[32'h40] = 8'h11; mem[32'h41] = 8'h22; mem[32'h42] = 8'h33; mem[32'h43] = 8'h44;
        mem[32'h1FFFE] = 8'hAA; mem[32'h1FFFF] = 8'hBB;

        test_reset();
        test_single();
        test_back_to_back();
        test_disturb();
        test_wrap();
        test_misaligned_hi();
        test_idle_hold();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, width of byte address to instruction memory.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pc  input  32  byte address of instruction requested by PC register.
REQ-005 ce  input  1  fetch request from PC register; 1 = fetch pc.
REQ-006 stall_req  output  1  1 while a fetch is in progress; PC register holds pc while high.
REQ-007 inst  output  32  assembled instruction, little-endian.
REQ-008 inst_valid  output  1  one-cycle pulse; inst holds a new instruction.
REQ-009 mem_a  output  ADDR_WIDTH  byte address to instruction memory.
REQ-010 mem_rd  output  1  read strobe to instruction memory.
REQ-011 mem_din  input  8  read data; valid the cycle after mem_a/mem_rd are sampled by memory (1-cycle synchronous read).

Function
REQ-012 The block SHALL be the memory-side responder to the PC register: accept a pc/ce request and return one 32-bit instruction from a byte-wide memory.
REQ-013 States: IDLE, FETCH; FETCH uses 3-bit counter cnt 0..4; all outputs registered.
REQ-014 IDLE, ce=1 at edge E0: latch pc into addr_q, mem_a<=pc[ADDR_WIDTH-1:0], mem_rd<=1, stall_req<=1, cnt<=0, go FETCH.
REQ-015 IDLE, ce=0: mem_rd=0, stall_req=0, mem_a holds, no state change.
REQ-016 FETCH edges E1..E3: mem_a<=addr_q+cnt+1 (bytes +1,+2,+3), mem_rd stays 1.
REQ-017 FETCH edges E2..E5: capture mem_din into byte lane cnt-1 (E2->inst[7:0], E3->[15:8], E4->[23:16], E5->[31:24]).
REQ-018 Edge E4: mem_rd<=0.
REQ-019 Edge E5: inst<=assembled word, inst_valid<=1, stall_req<=0, go IDLE; latency ce-sample to inst_valid = 5 cycles.
REQ-020 inst_valid SHALL be high exactly one cycle per fetch; inst SHALL hold its value until the next E5.
REQ-021 Next request accepted earliest at E6 (first IDLE edge); minimum request spacing 6 cycles.
REQ-022 pc and ce changes during FETCH SHALL be ignored; fetch completes on latched addr_q.
REQ-023 Address arithmetic modulo 2^ADDR_WIDTH: addr_q+i wraps (e.g. max-address byte followed by byte 0).
REQ-024 pc bits above ADDR_WIDTH-1 SHALL be discarded; misaligned pc (pc[1:0]!=0) fetched as-is, no error.
REQ-025 No output SHALL depend combinationally on any input.

Reset
REQ-026 rst=1 SHALL immediately, independent of clk, force: state IDLE, cnt 0, addr_q 0, mem_a 0, mem_rd 0, stall_req 0, inst 32'h00000000, inst_valid 0.
REQ-027 Reset during FETCH SHALL abort the fetch; no inst_valid pulse for the aborted request.
REQ-028 First request SHALL be accepted on the first rising edge with rst=0 and ce=1.

Verification
REQ-029 Single fetch: memory bytes 0..3 = 13,05,10,00, pc=0, ce=1 one cycle -> mem_a 0,1,2,3 on E0..E3; inst=32'h00100513, inst_valid high only cycle after E5.
REQ-030 Back-to-back: ce held 1, pc=0 then 4 -> second fetch mem_a=4 starts E6; stall_req low exactly one cycle between fetches; two inst_valid pulses 6 cycles apart.
REQ-031 Mid-fetch disturbance: pc 8->0x40 and ce 1->0 at E2 -> fetch completes from addresses 8..11, inst_valid at E5.
REQ-032 Wrap: ADDR_WIDTH=17, pc=0x1FFFE -> mem_a sequence 1FFFE,1FFFF,00000,00001.
REQ-033 Async reset: rst pulse between E3 and E4, no clock edge -> all outputs zero immediately; no inst_valid; next ce=1 fetch correct.
REQ-034 Idle hold: ce=0 for 20 cycles after a fetch -> mem_rd=0, stall_req=0, inst unchanged, inst_valid=0.
